// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store controller: FSM states,
// data-memory MemOp codes, response error codes and RISC-V funct3 values.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // MemOp encoding understood by data_mem
  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b011;
  localparam logic [2:0] MOP_HU = 3'b100;

  // Response error codes
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // RISC-V load/store funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_opmap.sv
// Combinational request decoder: translates (we, funct3, addr) into the
// data-memory MemOp and a prioritised error code (illegal > misaligned > range).
// The alignment check exists only when LSU_MISALIGN_TRAP_EN is defined;
// otherwise misaligned accesses go to memory at the raw address.
module lsu_opmap
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic [2:0]  mem_op_o,
  output logic [1:0]  err_o
);

  logic illegal;
  logic misalign;
  logic out_of_range;
  logic unused_addr;

  // Low address bits only feed the optional alignment check.
  assign unused_addr = ^addr_i[ADDR_W-1:0];

  assign out_of_range = |addr_i[31:ADDR_W];

  // funct3 to MemOp; unsigned loads have no store counterpart.
  always_comb begin
    mem_op_o = MOP_B;
    illegal  = 1'b0;
    case (funct3_i)
      F3_B:    mem_op_o = MOP_B;
      F3_H:    mem_op_o = MOP_H;
      F3_W:    mem_op_o = MOP_W;
      F3_BU: begin
        mem_op_o = MOP_BU;
        illegal  = we_i;
      end
      F3_HU: begin
        mem_op_o = MOP_HU;
        illegal  = we_i;
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need addr[0]==0, words need addr[1:0]==0.
  always_comb begin
    misalign = 1'b0;
    case (funct3_i)
      F3_H, F3_HU: misalign = addr_i[0];
      F3_W:        misalign = |addr_i[1:0];
      default:     misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Error priority: illegal funct3, then misalignment, then range.
  always_comb begin
    err_o = ERR_NONE;
    if (illegal)           err_o = ERR_ILLEGAL;
    else if (misalign)     err_o = ERR_MISALIGN;
    else if (out_of_range) err_o = ERR_RANGE;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between execute/writeback and data_mem.
// One transaction at a time: IDLE accepts, ISSUE/WAIT drive the memory port
// for 1+MEM_LAT cycles, RESP holds the response until writeback takes it.
// Optional build macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses).
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid never waits on ready, and a response held with rsp_ready low
// keeps every response field stable. req_ready depends on state only.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [2:0]        mem_op,
  output logic              mem_wr,
  input  logic [31:0]       mem_dout,
  output logic [1:0]        dbg_state
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              we_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [1:0]        err_q;
  logic [2:0]        cnt_q;

  logic [2:0]        map_op;
  logic [1:0]        map_err;
  logic              req_fire;
  logic              mem_active;

  lsu_opmap #(
    .ADDR_W (ADDR_W)
  ) u_opmap (
    .we_i     (req_we),
    .funct3_i (req_funct3),
    .addr_i   (req_addr),
    .mem_op_o (map_op),
    .err_o    (map_err)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign req_fire   = req_valid & req_ready;
  assign mem_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  // Next-state logic; errored requests skip the memory entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_fire) state_d = (map_err != ERR_NONE) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == 3'd0) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Request capture, WAIT down-counter and load-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      op_q    <= MOP_B;
      rd_q    <= '0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      if (req_fire) begin
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        we_q    <= req_we;
        op_q    <= map_op;
        rd_q    <= req_rd;
        err_q   <= map_err;
        rdata_q <= '0;
      end
      if (state_q == ST_ISSUE) begin
        cnt_q <= LAT_M1;
      end else if (state_q == ST_WAIT) begin
        if (cnt_q != 3'd0)  cnt_q   <= cnt_q - 3'd1;
        else if (!we_q)     rdata_q <= mem_dout;
      end
    end
  end

  // Memory port shows the captured request in ISSUE/WAIT, idle LB@0 otherwise.
  assign mem_addr  = mem_active ? addr_q  : '0;
  assign mem_din   = mem_active ? wdata_q : '0;
  assign mem_op    = mem_active ? op_q    : MOP_B;
  assign mem_wr    = mem_active & we_q;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_rd    = rd_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized traffic,
// a byte-array reference model, and a scoreboard monitor on the response port.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int MEM_LAT   = 1;
  localparam int ADDR_W    = 12;
  localparam int MEM_BYTES = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic [4:0]        req_rd;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [4:0]        rsp_rd;
  logic [1:0]        rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [2:0]        mem_op;
  logic              mem_wr;
  logic [31:0]       mem_dout = '0;
  logic [1:0]        dbg_state;

  lsu_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_op     (mem_op),
    .mem_wr     (mem_wr),
    .mem_dout   (mem_dout),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- data memory emulation (data_mem behaviour) ----------------
  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic int store_bytes(input logic [2:0] op);
    case (op)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mem_read(input logic [ADDR_W-1:0] a, input logic [2:0] op);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[a + ADDR_W'(i)];
    case (op)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b011:  return {24'h0, w[7:0]};
      3'b100:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < store_bytes(mem_op); i++) mem[mem_addr + ADDR_W'(i)] <= mem_din[8*i +: 8];
    end
    mem_dout <= mem_read(mem_addr, mem_op);
  end

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, output logic [31:0] rdata,
                                    output logic [1:0] err);
    int          size;
    bit          legal;
    logic [31:0] a;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    rdata = 32'h0;
    err   = 2'b00;
    v     = 32'h0;
    if (!legal) err = 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
    else if (addr % size != 0) err = 2'b01;
`endif
    else if (addr >= MEM_BYTES) err = 2'b10;
    else if (we) begin
      for (int i = 0; i < size; i++) begin
        a = addr + i;
        ref_mem[a[ADDR_W-1:0]] = wdata[8*i +: 8];
      end
    end else begin
      for (int i = 0; i < size; i++) begin
        a = addr + i;
        v[8*i +: 8] = ref_mem[a[ADDR_W-1:0]];
      end
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      rdata = v;
    end
  endfunction

  // ---------------- scoreboard ----------------
  // {rdata[31:0], rd[4:0], err[1:0], latency[3:0], store_cycles[3:0]}
  logic [46:0] exp_q[$];

  bit in_txn   = 1'b0;
  int busy_cnt = 0;
  int wr_cnt   = 0;

  always @(negedge clk) begin
    logic [46:0] e;
    if (!rst) begin
      exp_q.delete();
      in_txn = 1'b0;
    end else if (!in_txn) begin
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_req_ready", req_ready, 1);
      check("idle_mem_wr",    mem_wr,    0);
      check("idle_mem_addr",  mem_addr,  0);
      check("idle_mem_op",    mem_op,    0);
      check("idle_mem_din",   mem_din,   0);
      if (req_valid && req_ready) begin
        in_txn   = 1'b1;
        busy_cnt = 0;
        wr_cnt   = 0;
      end
    end else begin
      if (mem_wr) wr_cnt++;
      if (!rsp_valid) begin
        busy_cnt++;
      end else if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata",    rsp_rdata, e[46:15]);
          check("rsp_rd",       rsp_rd,    e[14:10]);
          check("rsp_err",      rsp_err,   e[9:8]);
          check("rsp_latency",  busy_cnt,  e[7:4]);
          check("store_cycles", wr_cnt,    e[3:0]);
        end
        in_txn = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    logic [31:0] r;
    logic [1:0]  e;
    logic [3:0]  lat, wrc;
    int          t;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      check("req_ready_wait", req_ready, 1);
      return;
    end
    ref_model(we, f3, addr, wdata, r, e);
    lat = (e == 2'b00) ? 4'(1 + MEM_LAT) : 4'd0;
    wrc = (e == 2'b00 && we) ? 4'(1 + MEM_LAT) : 4'd0;
    exp_q.push_back({r, rd, e, lat, wrc});
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) check("rsp_valid_wait", rsp_valid, 1);
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd, input int hold);
    rsp_ready = (hold == 0);
    issue(we, f3, addr, wdata, rd);
    wait_valid();
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- main stimulus ----------------
  logic [2:0] legal_ld [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] cur;
    int          hold;

    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'd0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h10] = 8'h78; mem[16'h11] = 8'h56; mem[16'h12] = 8'h34; mem[16'h13] = 8'h12;
    mem[16'h80] = 8'h80;
    ref_mem[16'h10] = 8'h78; ref_mem[16'h11] = 8'h56; ref_mem[16'h12] = 8'h34; ref_mem[16'h13] = 8'h12;
    ref_mem[16'h80] = 8'h80;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_rd",    rsp_rd,    0);
    check("reset_rsp_err",   rsp_err,   0);
    check("reset_mem_wr",    mem_wr,    0);
    check("reset_mem_addr",  mem_addr,  0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // LW of a preloaded word
    txn(1'b0, F3_W, 32'h0000_0010, 32'h0, 5'd5, 0);
    // SH then LHU / LH
    txn(1'b1, F3_H,  32'h0000_0020, 32'hDEAD_BEEF, 5'd1, 0);
    txn(1'b0, F3_HU, 32'h0000_0020, 32'h0, 5'd2, 0);
    txn(1'b0, F3_H,  32'h0000_0020, 32'h0, 5'd3, 0);
    // Illegal funct3 on a load and on a store
    txn(1'b0, 3'b110, 32'h0000_0040, 32'h0, 5'd4, 0);
    txn(1'b1, F3_BU,  32'h0000_0040, 32'h1234_5678, 5'd6, 2);
    // Out of range
    txn(1'b0, F3_W, 32'h0000_1000, 32'h0, 5'd7, 0);
    // Misaligned word store, then read both neighbouring words
    txn(1'b1, F3_W, 32'h0000_0002, 32'hCAFE_F00D, 5'd8, 0);
    txn(1'b0, F3_W, 32'h0000_0000, 32'h0, 5'd10, 0);
    txn(1'b0, F3_W, 32'h0000_0004, 32'h0, 5'd11, 1);

    // Backpressure on an LB of byte 0x80
    rsp_ready = 1'b0;
    issue(1'b0, F3_B, 32'h0000_0080, 32'h0, 5'd9);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_req_ready", req_ready, 1);

    // Reset in the middle of a SW (data equals current contents)
    for (int i = 0; i < 4; i++) cur[8*i +: 8] = ref_mem[12'hF00 + 12'(i)];
    issue(1'b1, F3_W, 32'h0000_0F00, cur, 5'd12);
    @(posedge clk); #1;
    check("rst_pre_mem_wr", mem_wr, 1);
    rst = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_rd",    rsp_rd,    0);
    check("rst_rsp_err",   rsp_err,   0);
    check("rst_mem_wr",    mem_wr,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_din",   mem_din,   0);
    check("rst_mem_op",    mem_op,    0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, F3_BU, 32'h0000_0080, 32'h0, 5'd13, 0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = we ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, MEM_BYTES - 1));
      hold = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      txn(we, f3, addr, $urandom, 5'($urandom), hold);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
